// File: rtl/cp0_timer_intc_pkg.sv
// Shared CP0 timer/interrupt definitions.
// Holds the Cause.IP layout constants, the interrupt-number type and the
// priority encoder that the request logic uses.
package cp0_timer_intc_pkg;

  localparam int unsigned CP0_IP_W       = 8;
  localparam int unsigned CP0_IP_SW_W    = 2;
  localparam int unsigned CP0_IP_HW_BASE = 2;
  // Cause.TI bit position, used by CP0 when it reads back Cause.
  localparam int unsigned CAUSE_TI_BIT   = 30;
  // Prescaler width; it must hold COUNT_DIV-1 for COUNT_DIV up to 16.
  localparam int unsigned PRESC_W        = 4;

  typedef logic [2:0]          irq_num_t;
  typedef logic [CP0_IP_W-1:0] cp0_ip_t;

  // Returns the index of the highest set bit (IP7 has top priority), or 0 when none is set.
  function automatic irq_num_t highest_ip(input cp0_ip_t ip);
    irq_num_t idx;
    idx = '0;
    for (int i = 0; i < CP0_IP_W; i++) begin
      if (ip[i]) idx = irq_num_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cp0_timer_intc_if.sv
// CP0 register-file side of the timer/interrupt unit.
// master: the CP0 register file. It drives the Count/Compare writes and the
//         Status/Cause fields, and reads back Count, Compare, TI and IP.
// slave:  cp0_timer_intc.
interface cp0_timer_intc_if;
  import cp0_timer_intc_pkg::*;

  logic                   count_we_i;
  logic                   compare_we_i;
  logic [31:0]            wdata_i;
  logic                   status_ie_i;
  logic                   status_exl_i;
  logic                   status_erl_i;
  logic [CP0_IP_W-1:0]    status_im_i;
  logic [CP0_IP_SW_W-1:0] cause_ip_sw_i;
  logic [31:0]            count_o;
  logic [31:0]            compare_o;
  logic                   ti_o;
  cp0_ip_t                ip_o;

  modport master (
    output count_we_i, compare_we_i, wdata_i, status_ie_i, status_exl_i, status_erl_i,
           status_im_i, cause_ip_sw_i,
    input  count_o, compare_o, ti_o, ip_o
  );

  modport slave (
    input  count_we_i, compare_we_i, wdata_i, status_ie_i, status_exl_i, status_erl_i,
           status_im_i, cause_ip_sw_i,
    output count_o, compare_o, ti_o, ip_o
  );

endinterface

// File: rtl/cp0_int_line.sv
// One hardware interrupt line.
// It synchronises the asynchronous input and keeps a history flop for rise
// detection. It reports either the synced level (EDGE=0) or a rise-set,
// clear-reset pending latch (EDGE=1).
// Ports: clk, rst (sync, active-high), irq_i (async line), clr_i (one-cycle
// clear of the edge latch), pending_o (pending status of this line).
module cp0_int_line #(
  parameter bit          EDGE        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic clr_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   latch_q, latch_d;
  logic                   synced, rise;

  always_comb begin
    synced  = sync_q[SYNC_STAGES-1];
    rise    = synced & ~hist_q;
    sync_d  = (sync_q << 1) | SYNC_STAGES'(irq_i);
    hist_d  = synced;
    // A rise in the same cycle as a clear wins, so the new event is not lost.
    latch_d = rise | (latch_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      latch_q <= latch_d;
    end
  end

  assign pending_o = EDGE ? latch_q : synced;

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 timer and interrupt unit.
// Provides a prescaled Count, a Compare register with a sticky timer
// interrupt, synchronised level/edge hardware lines, the Cause.IP view, and a
// registered, prioritised interrupt request.
// Ports: clk, rst (sync, active-high); cp0 (register-file side: Count/Compare
// writes, Status/Cause fields, Count/Compare/TI/IP readback); hw_int_i (async
// lines), int_edge_clr_i (edge latch clears), irq_o / irq_num_o (request to
// the exception stage).
module cp0_timer_intc
  import cp0_timer_intc_pkg::*;
#(
  parameter int unsigned N_HW_INT    = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned TIMER_IP    = 7,
  parameter logic [5:0]  EDGE_MASK   = 6'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  cp0_timer_intc_if.slave     cp0,
  input  logic [N_HW_INT-1:0] hw_int_i,
  input  logic [N_HW_INT-1:0] int_edge_clr_i,
  output logic                irq_o,
  output irq_num_t            irq_num_o
);

  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(COUNT_DIV - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [31:0]         count_q, count_d;
  logic [31:0]         compare_q, compare_d;
  logic [31:0]         count_inc;
  logic                ti_q, ti_d;
  logic                tick;
  logic                irq_q, irq_d;
  irq_num_t            irq_num_q, irq_num_d;
  logic [N_HW_INT-1:0] pending;
  cp0_ip_t             ip, masked;

  for (genvar i = 0; i < N_HW_INT; i++) begin : g_line
    cp0_int_line #(
      .EDGE        (EDGE_MASK[i]),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .irq_i     (hw_int_i[i]),
      .clr_i     (int_edge_clr_i[i]),
      .pending_o (pending[i])
    );
  end

  // Count / Compare / timer interrupt
  always_comb begin
    tick      = (presc_q == PrescMax);
    count_inc = count_q + 32'd1;
    presc_d   = presc_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;

    if (cp0.count_we_i) begin
      count_d = cp0.wdata_i;
      presc_d = '0;
    end else if (tick) begin
      count_d = count_inc;
      presc_d = '0;
    end

    // Only a tick can fire the timer; a Count write landing on Compare does not.
    if (cp0.compare_we_i) begin
      compare_d = cp0.wdata_i;
      ti_d      = 1'b0;
    end else if (!cp0.count_we_i && tick && (count_inc == compare_q)) begin
      ti_d      = 1'b1;
    end
  end

  // Cause.IP view and request
  always_comb begin
    ip = '0;
    ip[CP0_IP_SW_W-1:0] = cp0.cause_ip_sw_i;
    for (int i = 0; i < N_HW_INT; i++) begin
      ip[CP0_IP_HW_BASE + i] = pending[i];
    end
    ip[TIMER_IP] = ip[TIMER_IP] | ti_q;

    masked    = ip & cp0.status_im_i;
    irq_d     = (|masked) & cp0.status_ie_i & ~cp0.status_exl_i & ~cp0.status_erl_i;
    irq_num_d = irq_d ? highest_ip(masked) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      irq_q     <= 1'b0;
      irq_num_q <= '0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      irq_q     <= irq_d;
      irq_num_q <= irq_num_d;
    end
  end

  assign cp0.count_o   = count_q;
  assign cp0.compare_o = compare_q;
  assign cp0.ti_o      = ti_q;
  assign cp0.ip_o      = ip;
  assign irq_o         = irq_q;
  assign irq_num_o     = irq_num_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc.
// dut_a: COUNT_DIV=2, line 1 edge-triggered. dut_b: COUNT_DIV=1, all lines level.
module tb_cp0_timer_intc;

  logic       clk;
  logic       rst;
  logic [5:0] hw_a, clr_a, hw_b, clr_b;
  logic       irq_a, irq_b;
  logic [2:0] num_a, num_b;
  int         checks;
  int         errors;

  cp0_timer_intc_if ifa ();
  cp0_timer_intc_if ifb ();

  cp0_timer_intc #(
    .COUNT_DIV (2),
    .EDGE_MASK (6'b000010)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .cp0            (ifa),
    .hw_int_i       (hw_a),
    .int_edge_clr_i (clr_a),
    .irq_o          (irq_a),
    .irq_num_o      (num_a)
  );

  cp0_timer_intc #(
    .COUNT_DIV (1)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .cp0            (ifb),
    .hw_int_i       (hw_b),
    .int_edge_clr_i (clr_b),
    .irq_o          (irq_b),
    .irq_num_o      (num_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    hw_a = '0; clr_a = '0; hw_b = '0; clr_b = '0;
    ifa.count_we_i = 1'b0; ifa.compare_we_i = 1'b0; ifa.wdata_i = '0;
    ifa.status_ie_i = 1'b0; ifa.status_exl_i = 1'b0; ifa.status_erl_i = 1'b0;
    ifa.status_im_i = '0; ifa.cause_ip_sw_i = '0;
    ifb.count_we_i = 1'b0; ifb.compare_we_i = 1'b0; ifb.wdata_i = '0;
    ifb.status_ie_i = 1'b1; ifb.status_exl_i = 1'b0; ifb.status_erl_i = 1'b0;
    ifb.status_im_i = 8'h80; ifb.cause_ip_sw_i = '0;

    // Reset state
    step();
    chk("rst_count", ifa.count_o, 32'h0);
    chk("rst_compare", ifa.compare_o, 32'h0);
    chk("rst_ti", 32'(ifa.ti_o), 32'h0);
    chk("rst_ip", 32'(ifa.ip_o), 32'h0);
    chk("rst_irq", 32'(irq_a), 32'h0);
    chk("rst_num", 32'(num_a), 32'h0);
    rst = 1'b0;

    // Wrap on dut_b (COUNT_DIV=1, compare=0)
    ifb.count_we_i = 1'b1; ifb.wdata_i = 32'hFFFF_FFFE;
    step();
    chk("wrap_wr", ifb.count_o, 32'hFFFF_FFFE);
    ifb.count_we_i = 1'b0;
    step();
    chk("wrap_ff", ifb.count_o, 32'hFFFF_FFFF);
    chk("wrap_ff_ti", 32'(ifb.ti_o), 32'h0);
    step();
    chk("wrap_0", ifb.count_o, 32'h0);
    chk("wrap_0_ti", 32'(ifb.ti_o), 32'h1);
    step();
    chk("wrap_irq", 32'(irq_b), 32'h1);
    chk("wrap_num", 32'(num_b), 32'h7);
    ifb.compare_we_i = 1'b1; ifb.count_we_i = 1'b1; ifb.wdata_i = 32'hFFFF_FFFF;
    step();
    chk("wrap_cmpclr_ti", 32'(ifb.ti_o), 32'h0);
    ifb.count_we_i = 1'b0; ifb.wdata_i = 32'h0;
    step();
    chk("wrap_race_cnt", ifb.count_o, 32'h0);
    chk("wrap_race_ti", 32'(ifb.ti_o), 32'h0);
    ifb.compare_we_i = 1'b0; ifb.count_we_i = 1'b1; ifb.wdata_i = 32'h0;
    step();
    chk("cntwr_eq_cmp_cnt", ifb.count_o, 32'h0);
    chk("cntwr_eq_cmp_ti", 32'(ifb.ti_o), 32'h0);
    ifb.count_we_i = 1'b0;

    // Timer match on dut_a (COUNT_DIV=2)
    ifa.status_ie_i = 1'b1; ifa.status_im_i = 8'h80;
    ifa.compare_we_i = 1'b1; ifa.wdata_i = 32'h13;
    step();
    chk("tmr_compare", ifa.compare_o, 32'h13);
    ifa.compare_we_i = 1'b0; ifa.count_we_i = 1'b1; ifa.wdata_i = 32'h10;
    step();
    chk("tmr_count_wr", ifa.count_o, 32'h10);
    ifa.count_we_i = 1'b0;
    step(5);
    chk("tmr_count_e5", ifa.count_o, 32'h12);
    chk("tmr_ti_e5", 32'(ifa.ti_o), 32'h0);
    step();
    chk("tmr_count_e6", ifa.count_o, 32'h13);
    chk("tmr_ti_e6", 32'(ifa.ti_o), 32'h1);
    chk("tmr_irq_e6", 32'(irq_a), 32'h0);
    step();
    chk("tmr_irq_e7", 32'(irq_a), 32'h1);
    chk("tmr_num_e7", 32'(num_a), 32'h7);
    ifa.compare_we_i = 1'b1; ifa.wdata_i = 32'h100;
    step();
    ifa.compare_we_i = 1'b0;
    chk("tmr_clr_ti", 32'(ifa.ti_o), 32'h0);
    chk("tmr_clr_irq_hold", 32'(irq_a), 32'h1);
    step();
    chk("tmr_clr_irq", 32'(irq_a), 32'h0);
    chk("tmr_clr_num", 32'(num_a), 32'h0);

    // Level line 0
    ifa.status_im_i = 8'h04;
    hw_a[0] = 1'b1;
    step();
    chk("lvl_e1", 32'(ifa.ip_o), 32'h00);
    step();
    chk("lvl_e2", 32'(ifa.ip_o), 32'h04);
    clr_a[0] = 1'b1;
    step();
    clr_a[0] = 1'b0;
    chk("lvl_irq", 32'(irq_a), 32'h1);
    chk("lvl_num", 32'(num_a), 32'h2);
    chk("lvl_clr_noeff", 32'(ifa.ip_o), 32'h04);
    step(7);
    hw_a[0] = 1'b0;
    step();
    chk("lvl_fall_e1", 32'(ifa.ip_o), 32'h04);
    step();
    chk("lvl_fall_e2", 32'(ifa.ip_o), 32'h00);
    ifa.status_im_i = 8'h00;
    step(2);

    // Edge line 1
    hw_a[1] = 1'b1;
    step(2);
    chk("edge_e2", 32'(ifa.ip_o), 32'h00);
    step();
    chk("edge_e3", 32'(ifa.ip_o), 32'h08);
    hw_a[1] = 1'b0;
    step(4);
    chk("edge_held", 32'(ifa.ip_o), 32'h08);
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    chk("edge_clr", 32'(ifa.ip_o), 32'h00);
    hw_a[1] = 1'b1;
    step(2);
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    hw_a[1] = 1'b0;
    chk("edge_set_beats_clr", 32'(ifa.ip_o), 32'h08);
    step(3);
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    chk("edge_clr2", 32'(ifa.ip_o), 32'h00);

    // Priority and gating: sw IP0, hw line 3 (IP5), timer (IP7)
    ifa.compare_we_i = 1'b1; ifa.wdata_i = 32'h51;
    step();
    ifa.compare_we_i = 1'b0; ifa.count_we_i = 1'b1; ifa.wdata_i = 32'h50;
    hw_a[3] = 1'b1; ifa.cause_ip_sw_i = 2'b01;
    step();
    ifa.count_we_i = 1'b0;
    step(2);
    chk("pri_ip", 32'(ifa.ip_o), 32'hA1);
    ifa.status_im_i = 8'hFF;
    step();
    chk("pri_irq_ff", 32'(irq_a), 32'h1);
    chk("pri_num_ff", 32'(num_a), 32'h7);
    ifa.status_im_i = 8'h7F;
    step();
    chk("pri_num_7f", 32'(num_a), 32'h5);
    ifa.status_im_i = 8'h01;
    step();
    chk("pri_irq_sw", 32'(irq_a), 32'h1);
    chk("pri_num_sw", 32'(num_a), 32'h0);
    ifa.status_im_i = 8'hFF; ifa.status_exl_i = 1'b1;
    step();
    chk("pri_exl", 32'(irq_a), 32'h0);
    ifa.status_exl_i = 1'b0; ifa.status_erl_i = 1'b1;
    step();
    chk("pri_erl", 32'(irq_a), 32'h0);
    ifa.status_erl_i = 1'b0;
    step();
    chk("pri_reen", 32'(irq_a), 32'h1);
    chk("pri_reen_num", 32'(num_a), 32'h7);

    // Reset mid-operation with ti, a level line and an edge latch pending
    hw_a[1] = 1'b1;
    step(3);
    hw_a[1] = 1'b0;
    step(2);
    chk("mid_pre_ip", 32'(ifa.ip_o), 32'hA9);
    ifa.cause_ip_sw_i = 2'b00;
    rst = 1'b1; ifa.count_we_i = 1'b1; ifa.wdata_i = 32'h1234;
    step();
    chk("mid_count", ifa.count_o, 32'h0);
    chk("mid_compare", ifa.compare_o, 32'h0);
    chk("mid_ti", 32'(ifa.ti_o), 32'h0);
    chk("mid_ip", 32'(ifa.ip_o), 32'h0);
    chk("mid_irq", 32'(irq_a), 32'h0);
    chk("mid_num", 32'(num_a), 32'h0);
    rst = 1'b0; ifa.count_we_i = 1'b0; hw_a = '0;
    step(3);
    chk("mid_after_ip", 32'(ifa.ip_o), 32'h0);
    chk("mid_after_count", ifa.count_o, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
